rectangle_round_ctrl: RTL and testbench



---
 rtl/rectangle_pkg.sv | 33 +++
 rtl/rectangle_rc_lfsr.sv | 27 ++
 rtl/rectangle_round_ctrl.sv | 102 ++++++++++
 tb/tb_rectangle_round_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rectangle_pkg.sv
// Shared constants, FSM encoding and the RC update rule for the RECTANGLE-80
// round controller and its companion blocks.
package rectangle_pkg;

    localparam int         NR_DEFAULT      = 25;
    localparam logic [4:0] RC_INIT_DEFAULT = 5'h01;

    localparam int RC_W    = 5;
    localparam int STATE_W = 64;
    localparam int KEY_W   = 80;
    localparam int CNT_W   = 5;
    localparam int ST_W    = 3;

    localparam logic [ST_W-1:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD_ENC  = 3'd1;
    localparam logic [ST_W-1:0] ST_ROUND_ENC = 3'd2;
    localparam logic [ST_W-1:0] ST_FINAL_ENC = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_LOAD  = ST_LOAD_ENC,
        S_ROUND = ST_ROUND_ENC,
        S_FINAL = ST_FINAL_ENC,
        S_DONE  = ST_DONE_ENC
    } ctrl_state_t;

    // Forward RC step used by encryption: shift left, feed back rc[4]^rc[2].
    function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

endpackage

// File: rtl/rectangle_rc_lfsr.sv
// 5-bit round-constant LFSR with a load-to-initial-value and a step enable.
module rectangle_rc_lfsr
    import rectangle_pkg::*;
#(
    parameter logic [RC_W-1:0] RC_INIT = RC_INIT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    output logic [RC_W-1:0] ov_rc
);

    logic [RC_W-1:0] rc_q;

    // Load wins over step so the controller can re-arm in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            rc_q <= RC_INIT;
        end else if (i_step) begin
            rc_q <= rc_next(rc_q);
        end
    end

    assign ov_rc = rc_q;

endmodule

// File: rtl/rectangle_round_ctrl.sv
// Round sequencer for RECTANGLE-80: start handshake, load/round/final strobes,
// round counter and RC generation, result held valid until acknowledged.
module rectangle_round_ctrl
    import rectangle_pkg::*;
#(
    parameter int              NR      = NR_DEFAULT,
    parameter logic [RC_W-1:0] RC_INIT = RC_INIT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_ack,
    output logic             o_ready,
    output logic             o_load_en,
    output logic             o_round_en,
    output logic             o_final_en,
    output logic [RC_W-1:0]  ov_rc,
    output logic [CNT_W-1:0] ov_round,
    output logic             o_valid
);

    if (NR < 1 || NR > 31) begin : g_nr_check
        $error("rectangle_round_ctrl: NR must be in 1..31");
    end

    localparam logic [CNT_W-1:0] NR_CNT = CNT_W'(NR);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rc_load, rc_step;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshakes: i_start is taken only in a cycle where o_ready=1; i_ack is
    // taken only in a cycle where o_valid=1; neither is ever queued.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rc_load    = 1'b0;
        rc_step    = 1'b0;
        o_ready    = 1'b0;
        o_load_en  = 1'b0;
        o_round_en = 1'b0;
        o_final_en = 1'b0;
        o_valid    = 1'b0;
        ov_round   = '0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                o_load_en = 1'b1;
                rc_load   = 1'b1;
                cnt_d     = CNT_W'(1);
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                o_round_en = 1'b1;
                ov_round   = cnt_q;
                rc_step    = 1'b1;
                if (cnt_q == NR_CNT) begin
                    cnt_d   = '0;
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINAL: begin
                o_final_en = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ack) begin
                    rc_load = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    rectangle_rc_lfsr #(
        .RC_INIT (RC_INIT)
    ) u_rc_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (rc_load),
        .i_step (rc_step),
        .ov_rc  (ov_rc)
    );

endmodule

// File: tb/tb_rectangle_round_ctrl.sv
// Directed bench for rectangle_round_ctrl: timing, RC sequence, ignored
// start/ack, mid-run reset, back-to-back operation and random exclusivity.
module tb_rectangle_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ack;
    logic       ready;
    logic       load_en;
    logic       round_en;
    logic       final_en;
    logic [4:0] rc;
    logic [4:0] round_idx;
    logic       valid;

    int n_checks = 0;
    int n_fails  = 0;

    logic [4:0] rc_tab [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                                5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                                5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                                5'h1B, 5'h17, 5'h0E, 5'h1D};
    logic [4:0] exp_q [$];

    rectangle_round_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_ack      (ack),
        .o_ready    (ready),
        .o_load_en  (load_en),
        .o_round_en (round_en),
        .o_final_en (final_en),
        .ov_rc      (rc),
        .ov_round   (round_idx),
        .o_valid    (valid)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, {31'b0, ready}, 32'd1);
        check_eq({tag, "_enables"}, {29'b0, load_en, round_en, final_en}, 32'd0);
        check_eq({tag, "_valid"}, {31'b0, valid}, 32'd0);
        check_eq({tag, "_rc"}, {27'b0, rc}, 32'h01);
        check_eq({tag, "_round"}, {27'b0, round_idx}, 32'd0);
    endtask

    // One full transaction from IDLE; pulse_k pulses start while at cycle k
    // after acceptance, done_start pulses start while in DONE.
    task automatic run_txn(input int pulse_k, input bit done_start, input string tag);
        logic [4:0] exp_rc;
        exp_q.delete();
        for (int i = 0; i < 25; i++) exp_q.push_back(rc_tab[i]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            check_eq({tag, "_load"}, {31'b0, load_en}, {31'b0, k == 1});
            check_eq({tag, "_round_en"}, {31'b0, round_en}, {31'b0, k >= 2 && k <= 26});
            check_eq({tag, "_final"}, {31'b0, final_en}, {31'b0, k == 27});
            check_eq({tag, "_ready"}, {31'b0, ready}, 32'd0);
            check_eq({tag, "_valid"}, {31'b0, valid}, 32'd0);
            if (k >= 2 && k <= 26) begin
                exp_rc = exp_q.pop_front();
                check_eq({tag, "_rc"}, {27'b0, rc}, {27'b0, exp_rc});
                check_eq({tag, "_round"}, {27'b0, round_idx}, k - 1);
            end else begin
                check_eq({tag, "_round0"}, {27'b0, round_idx}, 32'd0);
            end
            start = (k == pulse_k);
            step();
        end
        start = 1'b0;
        check_eq({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        for (int d = 0; d < 3; d++) begin
            check_eq({tag, "_done_valid"}, {31'b0, valid}, 32'd1);
            check_eq({tag, "_done_en"}, {29'b0, load_en, round_en, final_en}, 32'd0);
            check_eq({tag, "_done_ready"}, {31'b0, ready}, 32'd0);
            start = done_start && (d == 1);
            step();
        end
        start = 1'b0;
        check_eq({tag, "_valid_held"}, {31'b0, valid}, 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_idle({tag, "_after_ack"});
        step();
        check_eq({tag, "_no_queued_load"}, {31'b0, load_en}, 32'd0);
        check_eq({tag, "_still_idle"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        int guard;
        int nen;
        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("idle");

        // Stray ack in IDLE does nothing.
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_idle("stray_ack");

        run_txn(0, 1'b0, "basic");
        run_txn(11, 1'b1, "ignored_start");

        // Reset during round 13.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 14; k++) step();
        check_eq("mid_round_idx", {27'b0, round_idx}, 32'd13);
        check_eq("mid_round_rc", {27'b0, rc}, 32'h0F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_reset");
        run_txn(0, 1'b0, "post_reset");

        // Back-to-back with start held high.
        start = 1'b1;
        guard = 0;
        step();
        while (!valid && guard < 40) begin
            step();
            guard++;
        end
        check_eq("b2b_valid_cycles", guard + 1, 32'd28);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_eq("b2b_idle_ready", {31'b0, ready}, 32'd1);
        check_eq("b2b_idle_noload", {31'b0, load_en}, 32'd0);
        step();
        check_eq("b2b_load", {31'b0, load_en}, 32'd1);
        step();
        check_eq("b2b_round1", {27'b0, round_idx}, 32'd1);
        check_eq("b2b_rc1", {27'b0, rc}, 32'h01);
        step();
        check_eq("b2b_rc2", {27'b0, rc}, 32'h02);
        start = 1'b0;

        // Random start/ack/reset: enable exclusivity and no X outputs.
        for (int i = 0; i < 10000; i++) begin
            start = ($urandom_range(1, 0) == 1);
            ack   = ($urandom_range(2, 0) == 0);
            rst   = ($urandom_range(99, 0) == 0);
            step();
            nen = int'(load_en) + int'(round_en) + int'(final_en);
            check_eq("rand_exclusive", {31'b0, nen <= 1}, 32'd1);
            check_eq("rand_no_x",
                     {31'b0, $isunknown({ready, load_en, round_en, final_en, rc, round_idx, valid})},
                     32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
